// File: rtl/uart_mmio_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/BAUD registers, transmit FIFO, 8N1 serializer.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.

typedef enum logic [1:0] {MEM_BYTE, MEM_HALF, MEM_WORD, MEM_DWORD} mem_op_t;

module uart_mmio_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          DIV_RESET  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  mem_op_t     mem_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        tx,
    output logic        irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [7:0]      fifo_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [15:0]     baud_q, baud_d;
    logic [15:0]     div_q, div_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;

    logic       hit, wr_tx, wr_st, wr_baud;
    logic       full, empty, busy, pop, push, bit_end;
    logic [3:0] off;
    logic [6:0] cnt7;
    logic       unused_ok;

    assign hit     = addr[31:4] == BASE_ADDR[31:4];
    assign off     = addr[3:0];
    assign wr_tx   = wr_en && hit && (off == 4'h0);
    assign wr_st   = wr_en && hit && (off == 4'h4);
    assign wr_baud = wr_en && hit && (off == 4'h8);

    assign full    = count_q == CW'(FIFO_DEPTH);
    assign empty   = count_q == '0;
    assign busy    = state_q != IDLE;
    assign pop     = (state_q == IDLE) && !empty;
    // A full FIFO still accepts a store when the serializer drains a slot on the same edge.
    assign push    = wr_tx && (!full || pop);
    assign bit_end = cnt_q == (div_q - 16'd1);
    assign cnt7    = 7'(count_q);
    assign irq     = empty && (state_q == IDLE);

    // Access width and upper store bits have no effect on this block.
    assign unused_ok = ^{mem_ctrl, data_in[31:16]};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        ovf_d    = ovf_q;
        baud_d   = baud_q;
        state_d  = state_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (wr_tx && full && !pop) ovf_d = 1'b1;
        else if (wr_st)            ovf_d = 1'b0;
        if (wr_baud) baud_d = data_in[15:0];

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = START;
                    shift_d = fifo_q[rd_ptr_q];
                    div_d   = (baud_q == 16'd0) ? 16'd1 : baud_q;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                cnt_d = bit_end ? '0 : cnt_q + 16'd1;
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                cnt_d = bit_end ? '0 : cnt_q + 16'd1;
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                    if (bit_q == 3'd7) state_d = PARITY;
`else
                    if (bit_q == 3'd7) state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                cnt_d = bit_end ? '0 : cnt_q + 16'd1;
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                cnt_d = bit_end ? '0 : cnt_q + 16'd1;
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[bit_q];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx = ^shift_q;
`endif
            default: tx = 1'b1;
        endcase
    end

    always_comb begin
        data_out = '0;
        if (hit) begin
            case (off)
                4'h4:    data_out = {17'd0, cnt7, 4'd0, ovf_q, busy, empty, full};
                4'h8:    data_out = {16'd0, baud_q};
                default: data_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) fifo_q[wr_ptr_q] <= data_in[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            baud_q   <= 16'(DIV_RESET);
            div_q    <= 16'd1;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            baud_q   <= baud_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
        end
    end

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Scoreboard bench for uart_mmio_tx: stimulus queues expected frames, a serial monitor checks tx bit by bit.
module tb_uart_mmio_tx;
    localparam logic [31:0] BASE = 32'h1000_0000;

    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] div;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    mem_op_t     mem_ctrl;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        tx;
    logic        irq;

    frame_t sb[$];
    int     checks = 0;
    int     errors = 0;

    always #5 clk = ~clk;

    uart_mmio_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .DIV_RESET(16)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .mem_ctrl(mem_ctrl), .addr(addr),
        .data_in(data_in), .data_out(data_out), .tx(tx), .irq(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; addr = a; data_in = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a; #1;
        chk(name, data_out, exp);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (!(irq === 1'b1 && sb.size() == 0) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        chk({name, "_irq"}, {31'd0, irq}, 32'd1);
        chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    // Checks one frame; the first start-bit cycle was already seen low by the caller.
    task automatic run_frame(input frame_t f);
        logic [10:0] bits;
        int          nb;
`ifdef UART_TX_PARITY_EN
        nb   = 11;
        bits = {1'b1, ^f.data, f.data, 1'b0};
`else
        nb   = 10;
        bits = {1'b0, 1'b1, f.data, 1'b0};
`endif
        for (int b = 0; b < nb; b++) begin
            logic got;
            got = bits[b];
            for (int c = 0; c < int'(f.div); c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (reset) return;
                if (tx !== bits[b] && got === bits[b]) got = tx;
            end
            chk($sformatf("frame_%02h_bit%0d", f.data, b), {31'd0, got}, {31'd0, bits[b]});
        end
    endtask

    initial begin : monitor
        int     idle_cnt;
        frame_t f;
        idle_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                idle_cnt = 0;
            end else if (tx === 1'b0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_start_tx", {31'd0, tx}, 32'd1);
                    for (int k = 0; k < 4000 && tx !== 1'b1 && !reset; k++) @(negedge clk);
                end else begin
                    f = sb.pop_front();
                    run_frame(f);
                end
                idle_cnt = 0;
            end else if (sb.size() != 0) begin
                idle_cnt++;
                if (idle_cnt > 3000) begin
                    chk("frame_start_timeout_pending", 32'(sb.size()), 32'd0);
                    void'(sb.pop_front());
                    idle_cnt = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset = 1'b1; wr_en = 1'b0; mem_ctrl = MEM_WORD; addr = '0; data_in = '0;
        @(posedge clk); #1;
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_irq", {31'd0, irq}, 32'd1);
        rd("reset_status", BASE + 32'h4, 32'h0000_0002);
        rd("reset_baud", BASE + 32'h8, 32'd16);
        rd("reset_txdata_read", BASE, 32'd0);
        tick(1);
        reset = 1'b0;
        tick(1);

        // BAUD=4, single byte 0x55
        wr(BASE + 32'h8, 32'd4);
        rd("baud4", BASE + 32'h8, 32'd4);
        sb.push_back(frame_t'{8'h55, 16'd4});
        wr(BASE, 32'h55);
        chk("tx_high_on_push_edge", {31'd0, tx}, 32'd1);
        chk("irq_low_queued", {31'd0, irq}, 32'd0);
        rd("status_one_queued", BASE + 32'h4, 32'h0000_0100);
        tick(1);
        chk("tx_low_after_pop", {31'd0, tx}, 32'd0);
        rd("status_busy", BASE + 32'h4, 32'h0000_0006);
        wait_drain("drain_55");

        // Fill FIFO: 9 stores, first popped, 8 held; 10th overflows
        for (int i = 0; i < 9; i++) begin
            sb.push_back(frame_t'{8'(8'hA0 + i), 16'd4});
            wr(BASE, 32'(8'hA0 + i));
        end
        rd("status_full", BASE + 32'h4, 32'h0000_0805);
        wr(BASE, 32'hEE);
        rd("status_overflow", BASE + 32'h4, 32'h0000_080D);
        wr(BASE + 32'h4, 32'h0);
        rd("status_ovf_cleared", BASE + 32'h4, 32'h0000_0805);
        wait_drain("drain_fill");

        // BAUD=0 acts as 1 cycle per bit
        wr(BASE + 32'h8, 32'd0);
        rd("baud0", BASE + 32'h8, 32'd0);
        sb.push_back(frame_t'{8'hFF, 16'd1});
        wr(BASE, 32'hFF);
        wait_drain("drain_ff");

        // BAUD change mid-frame applies to the next frame only
        wr(BASE + 32'h8, 32'd2);
        sb.push_back(frame_t'{8'h3C, 16'd2});
        sb.push_back(frame_t'{8'hC3, 16'd8});
        wr(BASE, 32'h3C);
        wr(BASE, 32'hC3);
        tick(2);
        wr(BASE + 32'h8, 32'd8);
        rd("baud8", BASE + 32'h8, 32'd8);
        wait_drain("drain_baud_change");

        // Reset mid-frame with 3 queued, coinciding with a store
        sb.push_back(frame_t'{8'h81, 16'd8});
        wr(BASE, 32'h81);
        wr(BASE, 32'h42);
        wr(BASE, 32'h43);
        wr(BASE, 32'h44);
        rd("status_three_queued", BASE + 32'h4, 32'h0000_0304);
        tick(20);
        reset = 1'b1; wr_en = 1'b1; addr = BASE; data_in = 32'h99;
        @(posedge clk); #1;
        wr_en = 1'b0;
        sb.delete();
        chk("midframe_reset_tx", {31'd0, tx}, 32'd1);
        chk("midframe_reset_irq", {31'd0, irq}, 32'd1);
        rd("midframe_reset_status", BASE + 32'h4, 32'h0000_0002);
        rd("midframe_reset_baud", BASE + 32'h8, 32'd16);
        reset = 1'b0;
        tick(1);
        rd("post_reset_status", BASE + 32'h4, 32'h0000_0002);

        // Unmapped offsets and out-of-window accesses
        rd("read_off_c", BASE + 32'hC, 32'd0);
        rd("read_base_plus_10", BASE + 32'h10, 32'd0);
        rd("read_miss_status", 32'h2000_0004, 32'd0);
        wr(BASE + 32'h10, 32'h5A);
        rd("status_after_miss_store", BASE + 32'h4, 32'h0000_0002);
        wr(32'h2000_0000, 32'h5B);
        wr(BASE + 32'hC, 32'h77);
        rd("status_after_ignored_stores", BASE + 32'h4, 32'h0000_0002);
        tick(100);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        chk("final_irq", {31'd0, irq}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_mmio_tx.md
UART_MMIO_TX -- requirements
Module: uart_mmio_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000: base of the 16-byte register window on the CPU data bus.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: transmit FIFO entries, power of two, 2..64.
REQ-003 SHALL have parameter DIV_RESET, default 16: reset value of the BAUD divisor.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port wr_en, input, 1: store strobe from the CPU MEM stage.
REQ-007 SHALL have port mem_ctrl, input, mem_op_t: access width; ignored, all accesses treated as word.
REQ-008 SHALL have port addr, input, 32: byte address.
REQ-009 SHALL have port data_in, input, 32: store data.
REQ-010 SHALL have port data_out, output, 32: load data, combinational from addr.
REQ-011 SHALL have port tx, output, 1: serial line, idle high.
REQ-012 SHALL have port irq, output, 1: high while FIFO empty and FSM IDLE (transmit drained).

Function
REQ-013 SHALL decode hit = addr[31:4]==BASE_ADDR[31:4]; offset = addr[3:0]; non-hit writes ignored, non-hit reads return 0.
REQ-014 SHALL map offset 0x0 TXDATA (W: push data_in[7:0]; R: 0), 0x4 STATUS, 0x8 BAUD (R/W, bits[15:0]); other offsets read 0, writes ignored.
REQ-015 SHALL define STATUS: [0] full, [1] empty, [2] busy (FSM not IDLE), [3] overflow (sticky), [14:8] FIFO count; other bits 0.
REQ-016 SHALL clear overflow on any write to STATUS.
REQ-017 SHALL push on the edge where wr_en & hit & offset==0x0; a push while full with no simultaneous pop SHALL be dropped and set overflow.
REQ-018 SHALL accept a push while full if a pop occurs on the same edge; count unchanged.
REQ-019 SHALL implement FSM IDLE -> START -> DATA -> STOP -> IDLE (PARITY between DATA and STOP only per REQ-030).
REQ-020 SHALL, in IDLE with FIFO non-empty, pop the head byte and enter START on the next edge; tx drops low from that edge.
REQ-021 SHALL hold each bit for div cycles, div latched from BAUD on IDLE->START; BAUD value 0 SHALL be treated as 1.
REQ-022 SHALL send start bit 0, 8 data bits LSB first, stop bit 1; frame = 10*div cycles.
REQ-023 SHALL return STOP->IDLE after its last cycle and may start the next frame on the following edge (one idle cycle minimum between frames).
REQ-024 SHALL let a BAUD write mid-frame take effect only at the next frame start.
REQ-025 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; count distinguishes full from empty.

Reset
REQ-026 SHALL, with reset high at an edge: FSM IDLE, FIFO emptied, pointers 0, overflow 0, BAUD = DIV_RESET, bit counters 0.
REQ-027 SHALL drive tx=1 and irq=1 from the first edge with reset high; data_out tracks reset state.
REQ-028 SHALL abort any frame in progress on reset; partially sent byte lost.
REQ-029 SHALL give reset priority over a simultaneous push.

Configuration
REQ-030 SHALL, with macro UART_TX_PARITY_EN defined, insert PARITY state after DATA sending even parity (XOR of data bits), frame = 11*div cycles; undefined: no PARITY state, frame = 10*div.

Verification
REQ-031 SHALL cover: reset, BAUD=4, store 0x55 to BASE+0 -> tx low from next edge for 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles; irq high after.
REQ-032 SHALL cover: store 9 bytes back-to-back (depth 8) while idle -> first popped, 8 stored, STATUS[14:8]=8, full=1, overflow=0; 10th store -> dropped, overflow=1; write STATUS -> overflow=0.
REQ-033 SHALL cover: store BAUD=0, send 0xFF -> each bit 1 cycle, frame 10 cycles (11 with UART_TX_PARITY_EN, parity bit 0).
REQ-034 SHALL cover: BAUD write 8 mid-frame at div 2 -> current frame keeps 2-cycle bits, next frame uses 8.
REQ-035 SHALL cover: reset asserted mid-DATA with 3 bytes queued -> tx=1, empty=1, busy=0, count=0 after the edge.
REQ-036 SHALL cover: load from BASE+0xC and from BASE+0x10 -> data_out=0; store to BASE+0x10 -> no FIFO change.
